// File: rtl/core_host_pkg.sv
// Shared types and helpers for the HW3 image-core host driver.
package core_host_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    ISSUE    = 3'd2,
    LOAD     = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int ERR_W = 16;

  // Source for "no mismatch seen yet" markers; callers slice to their width.
  localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

  // Error counter increment that sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  // States in which a run is in progress.
  function automatic logic is_busy(input state_e s);
    case (s)
      WAIT_RDY, ISSUE, LOAD: is_busy = 1'b1;
      default:               is_busy = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_host_driver_scoreboard.sv
// Scores every core output beat against the golden ROM.
// Keeps the golden index, a saturating mismatch count and the first failing index.
module core_scoreboard
  import core_host_pkg::*;
#(
  parameter int OUT_W      = 14,
  parameter int GOLD_DEPTH = 4096
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_clr,
  input  logic                          i_out_valid,
  input  logic [OUT_W-1:0]              i_out_data,
  input  logic [OUT_W-1:0]              i_gold_rom,
  output logic [$clog2(GOLD_DEPTH)-1:0] o_gold_addr,
  output logic [ERR_W-1:0]              o_err_cnt,
  output logic [$clog2(GOLD_DEPTH):0]   o_first_err
);

  localparam int GA_W = $clog2(GOLD_DEPTH);
  localparam logic [GA_W:0] GA_END  = (GA_W+1)'(GOLD_DEPTH);
  localparam logic [GA_W:0] FE_NONE = NO_ERR[GA_W:0];
  localparam logic [GA_W:0] GA_ONE  = (GA_W+1)'(1);

  logic [GA_W:0]      gold_q, gold_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [GA_W:0]      first_q, first_d;
  logic               mism_s;

  // Score the current beat; a start clear overrides the score of a coincident beat.
  always_comb begin
    gold_d  = gold_q;
    err_d   = err_q;
    first_d = first_q;
    mism_s  = 1'b0;
    if (i_out_valid) begin
      // Past the end of the golden image every beat is a mismatch.
      if (gold_q == GA_END) begin
        mism_s = 1'b1;
      end else begin
        mism_s = (i_out_data != i_gold_rom);
      end
    end else begin
      mism_s = 1'b0;
    end

    if (i_clr) begin
      gold_d  = '0;
      err_d   = '0;
      first_d = FE_NONE;
    end else if (i_out_valid) begin
      if (mism_s) begin
        err_d = sat_inc(err_q);
        if (first_q == FE_NONE) begin
          first_d = gold_q;
        end else begin
          first_d = first_q;
        end
      end else begin
        err_d   = err_q;
        first_d = first_q;
      end
      if (gold_q != GA_END) begin
        gold_d = gold_q + GA_ONE;
      end else begin
        gold_d = gold_q;
      end
    end else begin
      gold_d  = gold_q;
      err_d   = err_q;
      first_d = first_q;
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gold_q  <= '0;
      err_q   <= '0;
      first_q <= FE_NONE;
    end else begin
      gold_q  <= gold_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign o_gold_addr = gold_q[GA_W-1:0];
  assign o_err_cnt   = err_q;
  assign o_first_err = first_q;

endmodule

// File: rtl/core_host_driver.sv
// Host for the HW3 image core: issues ops from an op ROM, streams input
// images on LOAD ops, and scores core output through core_scoreboard.
module core_host_driver
  import core_host_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 14,
  parameter int OP_W       = 4,
  parameter int IN_DEPTH   = 2048,
  parameter int OP_DEPTH   = 1024,
  parameter int GOLD_DEPTH = 4096,
  parameter int LOAD_OP    = 0,
  parameter int TIMEOUT    = 65535
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [$clog2(OP_DEPTH):0]     i_op_num,
  output logic [$clog2(OP_DEPTH)-1:0]   o_op_addr,
  input  logic [OP_W-1:0]               i_op_rom,
  output logic [$clog2(IN_DEPTH)-1:0]   o_in_addr,
  input  logic [IN_W-1:0]               i_in_rom,
  output logic [$clog2(GOLD_DEPTH)-1:0] o_gold_addr,
  input  logic [OUT_W-1:0]              i_gold_rom,
  input  logic                          i_op_ready,
  output logic                          o_op_valid,
  output logic [OP_W-1:0]               o_op_mode,
  input  logic                          i_in_ready,
  output logic                          o_in_valid,
  output logic [IN_W-1:0]               o_in_data,
  input  logic                          i_out_valid,
  input  logic [OUT_W-1:0]              i_out_data,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_timeout,
  output logic [ERR_W-1:0]              o_err_cnt,
  output logic [$clog2(GOLD_DEPTH):0]   o_first_err
);

  localparam int OPA_W = $clog2(OP_DEPTH);
  localparam int INA_W = $clog2(IN_DEPTH);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [OPA_W:0]   OP_ONE   = (OPA_W+1)'(1);
  localparam logic [INA_W-1:0] IN_ONE   = INA_W'(1);
  localparam logic [INA_W-1:0] IN_LAST  = INA_W'(IN_DEPTH - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_FIRE  = WD_W'(TIMEOUT - 1);
  localparam logic [OP_W-1:0]  LOAD_M   = OP_W'(LOAD_OP);

  state_e            state_q, state_d;
  logic [OPA_W:0]    op_cnt_q, op_cnt_d;
  logic [INA_W-1:0]  in_addr_q, in_addr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [OP_W-1:0]   op_mode_q, op_mode_d;
  logic              op_valid_q, op_valid_d;
  logic              in_valid_q, in_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              start_ok_s;
  logic              wd_clr_s;

  assign start_ok_s = i_start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state, counters, watchdog and registered output strobes.
  always_comb begin
    state_d   = state_q;
    op_cnt_d  = op_cnt_q;
    in_addr_d = in_addr_q;
    op_mode_d = op_mode_q;
    timeout_d = timeout_q;
    wd_clr_s  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok_s) begin
          state_d   = WAIT_RDY;
          op_cnt_d  = '0;
          in_addr_d = '0;
          timeout_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      WAIT_RDY: begin
        if (op_cnt_q == i_op_num) begin
          state_d = DONE;
        end else if (i_op_ready) begin
          state_d   = ISSUE;
          op_mode_d = i_op_rom;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      ISSUE: begin
        // Single-cycle strobe; op_ready is not looked at here, so no double issue.
        wd_clr_s = 1'b1;
        op_cnt_d = op_cnt_q + OP_ONE;
        if (op_mode_q == LOAD_M) begin
          state_d = LOAD;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      LOAD: begin
        if (i_in_ready) begin
          wd_clr_s = 1'b1;
          if (in_addr_q == IN_LAST) begin
            in_addr_d = '0;
            state_d   = WAIT_RDY;
          end else begin
            in_addr_d = in_addr_q + IN_ONE;
            state_d   = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (i_out_valid || ((state_d == WAIT_RDY) && (state_q != WAIT_RDY))) begin
      wd_clr_s = 1'b1;
    end else begin
      wd_clr_s = wd_clr_s;
    end

    // Watchdog abort: a run that makes no progress for TIMEOUT cycles ends in DONE.
    if ((TIMEOUT != 0) && is_busy(state_q) && !wd_clr_s &&
        (wd_q == WD_FIRE) && (state_d != DONE)) begin
      state_d   = DONE;
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_d;
    end

    if (!is_busy(state_q) || wd_clr_s) begin
      wd_d = '0;
    end else if (wd_q != {WD_W{1'b1}}) begin
      wd_d = wd_q + WD_ONE;
    end else begin
      wd_d = wd_q;
    end

    op_valid_d = (state_d == ISSUE);
    in_valid_d = (state_d == LOAD);
    busy_d     = is_busy(state_d);
    done_d     = (state_d == DONE);
  end

  // Driver state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      op_cnt_q   <= '0;
      in_addr_q  <= '0;
      wd_q       <= '0;
      op_mode_q  <= '0;
      op_valid_q <= 1'b0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_cnt_q   <= op_cnt_d;
      in_addr_q  <= in_addr_d;
      wd_q       <= wd_d;
      op_mode_q  <= op_mode_d;
      op_valid_q <= op_valid_d;
      in_valid_q <= in_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  core_scoreboard #(
    .OUT_W      (OUT_W),
    .GOLD_DEPTH (GOLD_DEPTH)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (start_ok_s),
    .i_out_valid (i_out_valid),
    .i_out_data  (i_out_data),
    .i_gold_rom  (i_gold_rom),
    .o_gold_addr (o_gold_addr),
    .o_err_cnt   (o_err_cnt),
    .o_first_err (o_first_err)
  );

  assign o_op_addr  = op_cnt_q[OPA_W-1:0];
  assign o_in_addr  = in_addr_q;
  assign o_op_valid = op_valid_q;
  assign o_op_mode  = op_mode_q;
  assign o_in_valid = in_valid_q;
  // Data ROM is combinational on o_in_addr; gate so idle cycles show zero.
  assign o_in_data  = in_valid_q ? i_in_rom : {IN_W{1'b0}};
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_timeout  = timeout_q;

endmodule
